// File: rtl/key_scan.sv
// 4x4 matrix-keypad scanner: walks one active-low row per scan tick, debounces
// each new press and release, and reports the key as {row, col} with a strobe.
module key_scan #(
  parameter logic [15:0] COUNTER_MAX    = 16'd50000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       key_clk,
  input  logic       key_rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [15:0] TICK_LAST = COUNTER_MAX - 16'd1;
  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  logic [3:0]  col_meta_q, col_s_q;
  logic [15:0] tick_cnt_q;
  logic        tick;

  state_e      state_q, state_d;
  logic [1:0]  r_q, r_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        down_q, down_d;

  // Lowest column index whose line is pulled low; several keys in one row
  // resolve to the leftmost one.
  function automatic logic [1:0] low_col(input logic [3:0] p);
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!p[i]) low_col = 2'(i);
    end
  endfunction

  assign tick = (tick_cnt_q == TICK_LAST);

  // Idle columns float high, so the synchronizer resets to all-ones.
  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      tick_cnt_q <= 16'd0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
      tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      state_q <= ST_SCAN;
      r_q     <= 2'd0;
      cnt_q   <= 8'd0;
      pat_q   <= 4'hF;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (col_s_q == 4'hF) begin
            r_d = r_q + 2'd1;
          end else begin
            pat_d   = col_s_q;
            cnt_d   = 8'd0;
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (col_s_q != pat_q) begin
            state_d = ST_SCAN;
          end else if (cnt_q == DB_LAST) begin
            state_d = ST_PRESSED;
            valid_d = 1'b1;
            down_d  = 1'b1;
            code_d  = {r_q, low_col(pat_q)};
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_PRESSED: begin
          if (col_s_q == 4'hF) begin
            cnt_d   = 8'd0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (col_s_q != 4'hF) begin
            state_d = ST_PRESSED;
          end else if (cnt_q == DB_LAST) begin
            down_d  = 1'b0;
            r_d     = r_q + 2'd1;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  assign row       = ~(4'b0001 << r_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a combinational keypad model: a pressed key
// (r,c) connects column c to row r, all other columns stay pulled up.
module tb_key_scan;

  logic       key_clk;
  logic       key_rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] pressed;  // bit r*4+c set = key (r,c) held
  int n_checks = 0;
  int n_fail   = 0;

  key_scan #(
    .COUNTER_MAX   (16'd4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .key_clk  (key_clk),
    .key_rst  (key_rst),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial begin
    key_clk = 1'b0;
    forever #5 key_clk = ~key_clk;
  end

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0] row;
    logic       valid;
    logic       down;
  } scan_vec_t;

  typedef struct {
    string      name;
    logic [15:0] mask;
    logic [3:0] code;
    logic [3:0] row_held;
    logic [3:0] row_after;
  } press_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge key_clk);
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({name, " valid seen"}, 32'(got), 32'd1);
  endtask

  // Returns at the negedge right after the row switches to exp_row.
  task automatic wait_row_fresh(input string name, input logic [3:0] exp_row);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge key_clk);
      if (row != exp_row) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge key_clk);
        if (row == exp_row) begin
          got = 1'b1;
          break;
        end
      end
    end
    check({name, " row reached"}, 32'(got), 32'd1);
  endtask

  // Press, check report, hold 40 clocks (tick aligned), release, and check
  // that key_down falls exactly three ticks after the release is first seen.
  task automatic press_cycle(input press_vec_t v);
    int bad;
    pressed = v.mask;
    wait_valid(v.name);
    check({v.name, " code"}, 32'(key_code), 32'(v.code));
    check({v.name, " down"}, 32'(key_down), 32'd1);
    check({v.name, " row held"}, 32'(row), 32'(v.row_held));
    @(negedge key_clk);
    check({v.name, " valid width"}, 32'(key_valid), 32'd0);
    bad = 0;
    repeat (39) begin
      @(negedge key_clk);
      if (key_valid || !key_down || row != v.row_held) bad++;
    end
    check({v.name, " hold stable"}, 32'(bad), 32'd0);
    pressed = 16'h0;
    bad = 0;
    repeat (15) begin
      @(negedge key_clk);
      if (!key_down || key_valid) bad++;
    end
    check({v.name, " down until release done"}, 32'(bad), 32'd0);
    @(negedge key_clk);
    check({v.name, " down cleared"}, 32'(key_down), 32'd0);
    check({v.name, " scan resumes"}, 32'(row), 32'(v.row_after));
    check({v.name, " code held"}, 32'(key_code), 32'(v.code));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    scan_vec_t  idle_tbl[17];
    press_vec_t press_tbl[4];
    logic [3:0] idle_rows[4];
    int bad;

    idle_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 17; i++) begin
      idle_tbl[i].row   = idle_rows[(i / 4) % 4];
      idle_tbl[i].valid = 1'b0;
      idle_tbl[i].down  = 1'b0;
    end
    press_tbl[0] = '{"key21", 16'h1 << 9,                 4'h9, 4'b1011, 4'b0111};
    press_tbl[1] = '{"key31+33", (16'h1 << 13) | (16'h1 << 15), 4'hD, 4'b0111, 4'b1110};
    press_tbl[2] = '{"key00", 16'h1 << 0,                 4'h0, 4'b1110, 4'b1101};
    press_tbl[3] = '{"key12", 16'h1 << 6,                 4'h6, 4'b1101, 4'b1011};

    pressed = 16'h0;
    key_rst = 1'b1;
    repeat (3) @(negedge key_clk);
    check("reset row", 32'(row), 32'h0000_000E);
    check("reset code", 32'(key_code), 32'd0);
    check("reset valid", 32'(key_valid), 32'd0);
    check("reset down", 32'(key_down), 32'd0);

    // Idle scan: one row per 4 clocks, starting at the reset deassert edge.
    key_rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("idle row[%0d]", i), 32'(row), 32'(idle_tbl[i].row));
      check($sformatf("idle valid[%0d]", i), 32'(key_valid), 32'(idle_tbl[i].valid));
      check($sformatf("idle down[%0d]", i), 32'(key_down), 32'(idle_tbl[i].down));
      @(negedge key_clk);
    end

    foreach (press_tbl[k]) press_cycle(press_tbl[k]);

    // Press bounce on (0,3): matches two DEBOUNCE ticks, then opens.
    wait_row_fresh("pbounce", 4'b1110);
    pressed = 16'h1 << 3;
    bad = 0;
    repeat (12) begin
      @(negedge key_clk);
      if (key_valid || key_down) bad++;
    end
    pressed = 16'h0;
    repeat (8) begin
      @(negedge key_clk);
      if (key_valid || key_down) bad++;
    end
    check("pbounce no report", 32'(bad), 32'd0);
    check("pbounce code unchanged", 32'(key_code), 32'h6);
    check("pbounce back to scan", 32'(row), 32'b1101);

    // Release bounce on (1,0): open for two ticks, re-close, then release.
    wait_row_fresh("rbounce", 4'b1101);
    pressed = 16'h1 << 4;
    wait_valid("rbounce");
    check("rbounce code", 32'(key_code), 32'h4);
    pressed = 16'h0;
    bad = 0;
    repeat (8) begin
      @(negedge key_clk);
      if (!key_down || key_valid) bad++;
    end
    pressed = 16'h1 << 4;
    repeat (8) begin
      @(negedge key_clk);
      if (!key_down || key_valid) bad++;
    end
    pressed = 16'h0;
    repeat (15) begin
      @(negedge key_clk);
      if (!key_down || key_valid) bad++;
    end
    check("rbounce down held", 32'(bad), 32'd0);
    @(negedge key_clk);
    check("rbounce down cleared", 32'(key_down), 32'd0);
    check("rbounce row after", 32'(row), 32'b1011);

    // Reset while PRESSED on (2,2); the held key is re-reported afterwards.
    wait_row_fresh("midrst", 4'b1011);
    pressed = 16'h1 << 10;
    wait_valid("midrst");
    check("midrst code before", 32'(key_code), 32'hA);
    repeat (5) @(negedge key_clk);
    key_rst = 1'b1;
    #1;
    check("midrst row", 32'(row), 32'hE);
    check("midrst code", 32'(key_code), 32'd0);
    check("midrst valid", 32'(key_valid), 32'd0);
    check("midrst down", 32'(key_down), 32'd0);
    repeat (3) @(negedge key_clk);
    key_rst = 1'b0;
    bad = 0;
    repeat (23) begin
      @(negedge key_clk);
      if (key_valid || key_down) bad++;
    end
    check("midrst quiet after deassert", 32'(bad), 32'd0);
    @(negedge key_clk);
    check("midrst re-report valid", 32'(key_valid), 32'd1);
    check("midrst re-report code", 32'(key_code), 32'hA);
    check("midrst re-report down", 32'(key_down), 32'd1);
    check("midrst re-report row", 32'(row), 32'b1011);
    pressed = 16'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan.md
# key_scan

Matrix-keypad scanner for the CT137A board; the input-side counterpart of the multiplexed 7-segment driver. It drives one active-low row of a 4x4 keypad at a time and samples the four pulled-up column lines. Each new keypress is debounced, then reported as a 4-bit key code with a one-cycle valid strobe and a held key-down level. Downstream logic (menu/RTC set FSM) consumes `key_code`/`key_valid`.

## Interface
- `COUNTER_MAX`, default 16'd50000: scan tick period in clocks (1 ms at 50 MHz).
- `DEBOUNCE_TICKS`, default 20: consecutive stable ticks required to accept a press or a release (1..255).
- `key_clk`  in  1  system clock.
- `key_rst`  in  1  reset. Asynchronous and active-high.
- `col`  in  4  keypad column lines, active-low, pulled up, asynchronous to `key_clk`.
- `row`  out  4  row drive, active-low, exactly one bit low at all times.
- `key_code`  out  4  `{row_idx[1:0], col_idx[1:0]}` of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_down`  out  1  high from acceptance until the release is accepted.

## Operation
- `col` passes through a 2-flop synchronizer to give `col_s`. All decisions use `col_s`.
- Tick counter: 16-bit, runs 0..COUNTER_MAX-1 and wraps. `tick` = (counter == COUNTER_MAX-1). State changes occur only on `tick`, except reset.
- Row index `r` (2-bit). `row` = ~(4'b0001 << r).
- The FSM uses a debounce counter `cnt` (8-bit) and a latched column pattern `pat`.
- SCAN:
  - On tick, if `col_s` == 4'hF, then `r` <= `r`+1 (wraps 3->0).
  - Otherwise `pat` <= `col_s`, `cnt` <= 0, and the FSM goes to DEBOUNCE. `r` is frozen.
- DEBOUNCE: `row` is held.
  - On tick, if `col_s` != `pat`, go back to SCAN with `r` unchanged. No output change.
  - Otherwise `cnt` <= `cnt`+1.
  - When `cnt` == DEBOUNCE_TICKS-1 on a matching tick: go to PRESSED, set `key_valid` for 1 cycle, set `key_down`=1, and load `key_code` = {r, c}. `c` is the lowest index with `pat[c]`==0 (multi-key in one row: lowest column wins).
- PRESSED: `row` is held.
  - On tick, if `col_s` == 4'hF, then `cnt` <= 0 and go to RELEASE.
  - Column changes that are not 4'hF are ignored. No second report is made.
- RELEASE:
  - On tick, if `col_s` != 4'hF, go back to PRESSED with no new `key_valid`.
  - Otherwise `cnt` <= `cnt`+1.
  - When `cnt` == DEBOUNCE_TICKS-1: `key_down` <= 0, `r` <= `r`+1, and go to SCAN.
- Keys in other rows are invisible while not in SCAN (no ghost/rollover handling).
- `key_code` holds its value until the next accepted press.

## Timing
- Reset values: FSM=SCAN, counter=0, `r`=0, `row`=4'b1110, `cnt`=0, `pat`=4'hF, `key_code`=4'h0, `key_valid`=0, `key_down`=0. Synchronizer flops reset to 4'hF.
- Reset asserted mid-operation (any state) returns all of the above immediately. No `key_valid` is generated on deassert, even if a key is held. A held key is then re-detected through SCAN/DEBOUNCE.
- Row drive is stable for a full tick period before its columns are sampled. The sample is taken on the same tick that would advance `r`.
- Synchronizer latency: 2 clocks from a `col` pin change to `col_s`.
- Press latency: from the first tick that sees the key in SCAN, it takes DEBOUNCE_TICKS further ticks to reach the `key_valid` cycle. `key_valid` and the `key_down` rise occur in the same clock as the PRESSED entry and the `key_code` update. `key_code` is valid in that clock.
- Release latency: DEBOUNCE_TICKS ticks of continuous 4'hF after PRESSED sees the release.
- Worst-case detection delay: 4 ticks (one full row rotation), plus the debounce time.

## Test plan
Bench keypad model: `col[c]` = `row[r]` when key (r,c) is pressed, else 1. Use COUNTER_MAX=4 and DEBOUNCE_TICKS=3.
- Reset check: assert `key_rst` -> `row`=1110, `key_code`=0, `key_valid`=0, `key_down`=0. Release reset with no key -> `row` cycles 1110, 1101, 1011, 0111, changing every 4 clocks.
- Single press: hold key (2,1) -> exactly one `key_valid` pulse, `key_code`=4'h9, `key_down`=1, and `row` frozen at 1011. Release -> `key_down`=0 three ticks later, and scanning resumes at `row`=0111.
- Press bounce: hold key (0,3) for 2 ticks of DEBOUNCE, then release -> no `key_valid`, `key_code` unchanged, FSM back in SCAN.
- Release bounce: while PRESSED on (1,0), release for 2 ticks then re-press, then release for good -> `key_down` stays 1 through the bounce, no second `key_valid`, and `key_down` falls only after 3 clean ticks.
- Multi-key in one row: press (3,1) and (3,3) together -> `key_code`=4'hD.
- Reset mid-operation: assert `key_rst` while PRESSED on (2,2) -> all outputs reset immediately, no `key_valid` is generated at reset deassert, and the still-held key is re-reported as `key_code`=4'hA after the normal scan+debounce latency.
